// File: rtl/scope_cmd_pkg.sv
// Shared opcodes, response bytes, FSM state codes and the AFE gain table for scope_cmd_ctrl.
package scope_cmd_pkg;

  localparam logic [7:0] OpDumpCh  = 8'h01;
  localparam logic [7:0] OpCfgGain = 8'h02;
  localparam logic [7:0] OpTrigLvl = 8'h03;
  localparam logic [7:0] OpTrigPos = 8'h04;
  localparam logic [7:0] OpSetDec  = 8'h05;
  localparam logic [7:0] OpTrigCfg = 8'h06;
  localparam logic [7:0] OpTrigRd  = 8'h07;
  localparam logic [7:0] OpEepWrt  = 8'h08;
  localparam logic [7:0] OpEepRd   = 8'h09;
  localparam logic [7:0] OpGainRd  = 8'h0A;

  localparam logic [7:0] RespAck = 8'hA5;
  localparam logic [7:0] RespNak = 8'hEE;
  localparam logic [7:0] RespTmo = 8'hEF;

  // Write-command prefix shared by the gain DACs and the trigger DAC.
  localparam logic [7:0] SpiDacWr   = 8'h13;
  localparam logic [7:0] TrigLvlMin = 8'd46;
  localparam logic [7:0] TrigLvlMax = 8'd201;

  typedef logic [1:0] state_t;
  localparam state_t StIdle     = 2'd0;
  localparam state_t StDecode   = 2'd1;
  localparam state_t StSpiWait  = 2'd2;
  localparam state_t StRespWait = 2'd3;

  localparam logic [7:0] GainLut [8] = '{8'h02, 8'h05, 8'h09, 8'h14,
                                         8'h28, 8'h46, 8'h6B, 8'hDD};

endpackage

// File: rtl/afe_gain_lut.sv
// Maps a 3-bit AFE gain code to the 16-bit SPI word for the channel gain DAC.
module afe_gain_lut
  import scope_cmd_pkg::*;
(
  input  logic [2:0]  code_i,
  output logic [15:0] spi_word_o
);

  always_comb begin
    spi_word_o = {SpiDacWr, GainLut[code_i]};
  end

endmodule

// File: rtl/scope_cmd_ctrl.sv
// Host command decoder and capture configuration controller with SPI sequencing.
// Define CMD_TIMEOUT_EN to add an SPI watchdog that answers 0xEF after SPI_TMO cycles.
module scope_cmd_ctrl
  import scope_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned TRIG_POS_W = 9,
  parameter int unsigned DEC_W      = 4,
`ifdef CMD_TIMEOUT_EN
  parameter int unsigned SPI_TMO    = 1023,
`endif
  localparam int unsigned SS_W      = $clog2(NUM_CH + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_rdy,
  input  logic [23:0]           cmd,
  output logic                  clr_cmd_rdy,
  output logic                  wrt_SPI,
  output logic [SS_W-1:0]       ss,
  output logic [15:0]           SPI_data,
  input  logic                  SPI_done,
  input  logic [7:0]            EEP_data,
  output logic                  send_resp,
  output logic [7:0]            resp_data,
  input  logic                  resp_sent,
  input  logic                  set_capture_done,
  output logic [7:0]            trig_cfg,
  output logic [TRIG_POS_W-1:0] trig_pos,
  output logic [DEC_W-1:0]      decimator,
  output logic                  dump,
  output logic [1:0]            dump_ch,
  output logic [3*NUM_CH-1:0]   afe_gain
);

  localparam logic [SS_W-1:0] SsEep = SS_W'(NUM_CH + 1);

  state_t                state_q, state_d;
  logic [23:0]           cmd_q, cmd_d;
  logic                  clr_q, clr_d, wrt_q, wrt_d, send_q, send_d, dump_q, dump_d;
  logic [SS_W-1:0]       ss_q, ss_d;
  logic [15:0]           spi_data_q, spi_data_d;
  logic [7:0]            resp_q, resp_d;
  logic [5:0]            trig_cfg_q, trig_cfg_d;
  logic [TRIG_POS_W-1:0] trig_pos_q, trig_pos_d;
  logic [DEC_W-1:0]      dec_q, dec_d;
  logic [1:0]            dump_ch_q, dump_ch_d;
  logic [3*NUM_CH-1:0]   gain_q, gain_d;
`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(SPI_TMO + 1);
  logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  logic [7:0]  opcode, byte2, byte3;
  logic [1:0]  cc;
  logic        cc_ok, lvl_ok;
  logic [2:0]  gain_rd;
  logic [15:0] gain_word;
  logic        unused_bits;

  assign opcode      = cmd_q[23:16];
  assign byte2       = cmd_q[15:8];
  assign byte3       = cmd_q[7:0];
  assign cc          = byte2[1:0];
  assign cc_ok       = (32'(cc) < NUM_CH);
  assign lvl_ok      = (byte3 >= TrigLvlMin) && (byte3 <= TrigLvlMax);
  assign unused_bits = ^byte2[7:6];

  // Gain code travels in byte3[4:2]; byte2 carries only the channel.
  afe_gain_lut u_gain_lut (
    .code_i     (byte3[4:2]),
    .spi_word_o (gain_word)
  );

  always_comb begin
    gain_rd = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(cc) == i) gain_rd = gain_q[3*i +: 3];
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    clr_d      = 1'b0;
    wrt_d      = 1'b0;
    send_d     = 1'b0;
    dump_d     = 1'b0;
    ss_d       = ss_q;
    spi_data_d = spi_data_q;
    resp_d     = resp_q;
    trig_cfg_d = trig_cfg_q;
    trig_pos_d = trig_pos_q;
    dec_d      = dec_q;
    dump_ch_d  = dump_ch_q;
    gain_d     = gain_q;
`ifdef CMD_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        // clr_q guard keeps a still-held cmd_rdy from re-launching the finished command.
        if (cmd_rdy && !clr_q) begin
          cmd_d   = cmd;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StRespWait;
        send_d  = 1'b1;
        clr_d   = 1'b1;
        resp_d  = RespAck;
        case (opcode)
          OpDumpCh: begin
            if (cc_ok) begin
              state_d   = StIdle;
              send_d    = 1'b0;
              dump_d    = 1'b1;
              dump_ch_d = cc;
            end else begin
              resp_d = RespNak;
            end
          end
          OpCfgGain: begin
            if (cc_ok) begin
              state_d    = StSpiWait;
              send_d     = 1'b0;
              clr_d      = 1'b0;
              wrt_d      = 1'b1;
              ss_d       = SS_W'(cc) + SS_W'(1);
              spi_data_d = gain_word;
            end else begin
              resp_d = RespNak;
            end
          end
          OpTrigLvl: begin
            if (lvl_ok) begin
              state_d    = StSpiWait;
              send_d     = 1'b0;
              clr_d      = 1'b0;
              wrt_d      = 1'b1;
              ss_d       = '0;
              spi_data_d = {SpiDacWr, byte3};
            end else begin
              resp_d = RespNak;
            end
          end
          OpTrigPos: trig_pos_d = TRIG_POS_W'({byte2, byte3});
          OpSetDec:  dec_d      = byte3[DEC_W-1:0];
          OpTrigCfg: trig_cfg_d = byte3[5:0];
          OpTrigRd:  resp_d     = {2'b00, trig_cfg_q};
          OpEepWrt, OpEepRd: begin
            state_d    = StSpiWait;
            send_d     = 1'b0;
            clr_d      = 1'b0;
            wrt_d      = 1'b1;
            ss_d       = SsEep;
            spi_data_d = {(opcode == OpEepWrt) ? 2'b01 : 2'b00, byte2[5:0], byte3};
          end
          OpGainRd:  resp_d = cc_ok ? {5'b00000, gain_rd} : RespNak;
          default:   resp_d = RespNak;
        endcase
`ifdef CMD_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      StSpiWait: begin
        if (SPI_done) begin
          state_d = StRespWait;
          send_d  = 1'b1;
          clr_d   = 1'b1;
          resp_d  = (opcode == OpEepRd) ? EEP_data : RespAck;
          if (opcode == OpCfgGain) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (32'(cc) == i) gain_d[3*i +: 3] = byte3[4:2];
            end
          end
`ifdef CMD_TIMEOUT_EN
        end else if (tmo_cnt_q == TmoW'(SPI_TMO - 1)) begin
          state_d = StRespWait;
          send_d  = 1'b1;
          clr_d   = 1'b1;
          resp_d  = RespTmo;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      StRespWait: begin
        if (resp_sent) state_d = StIdle;
      end
    endcase
    // Capture-done wins over a same-cycle TRIG_CFG write for bit 5 only.
    if (set_capture_done) trig_cfg_d[5] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      clr_q      <= 1'b0;
      wrt_q      <= 1'b0;
      send_q     <= 1'b0;
      dump_q     <= 1'b0;
      ss_q       <= '0;
      spi_data_q <= '0;
      resp_q     <= '0;
      trig_cfg_q <= '0;
      trig_pos_q <= '0;
      dec_q      <= '0;
      dump_ch_q  <= '0;
      gain_q     <= '0;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      clr_q      <= clr_d;
      wrt_q      <= wrt_d;
      send_q     <= send_d;
      dump_q     <= dump_d;
      ss_q       <= ss_d;
      spi_data_q <= spi_data_d;
      resp_q     <= resp_d;
      trig_cfg_q <= trig_cfg_d;
      trig_pos_q <= trig_pos_d;
      dec_q      <= dec_d;
      dump_ch_q  <= dump_ch_d;
      gain_q     <= gain_d;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign clr_cmd_rdy = clr_q;
  assign wrt_SPI     = wrt_q;
  assign ss          = ss_q;
  assign SPI_data    = spi_data_q;
  assign send_resp   = send_q;
  assign resp_data   = resp_q;
  assign trig_cfg    = {2'b00, trig_cfg_q};
  assign trig_pos    = trig_pos_q;
  assign decimator   = dec_q;
  assign dump        = dump_q;
  assign dump_ch     = dump_ch_q;
  assign afe_gain    = gain_q;

endmodule

// File: tb/tb_scope_cmd_ctrl.sv
// Self-checking bench for scope_cmd_ctrl: directed cases plus random commands against a model.
module tb_scope_cmd_ctrl;

  localparam int unsigned NumCh    = 3;
  localparam int unsigned TrigPosW = 9;
  localparam int unsigned DecW     = 4;
  localparam int unsigned SsW      = $clog2(NumCh + 2);
`ifdef CMD_TIMEOUT_EN
  localparam int unsigned Tmo      = 40;
`endif

  logic                clk = 1'b0;
  logic                rst, cmd_rdy, SPI_done, resp_sent, set_capture_done;
  logic [23:0]         cmd;
  logic [7:0]          EEP_data;
  logic                clr_cmd_rdy, wrt_SPI, send_resp, dump;
  logic [SsW-1:0]      ss;
  logic [15:0]         SPI_data;
  logic [7:0]          resp_data, trig_cfg;
  logic [TrigPosW-1:0] trig_pos;
  logic [DecW-1:0]     decimator;
  logic [1:0]          dump_ch;
  logic [3*NumCh-1:0]  afe_gain;

  scope_cmd_ctrl #(
`ifdef CMD_TIMEOUT_EN
    .SPI_TMO    (Tmo),
`endif
    .NUM_CH     (NumCh),
    .TRIG_POS_W (TrigPosW),
    .DEC_W      (DecW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_rdy          (cmd_rdy),
    .cmd              (cmd),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .wrt_SPI          (wrt_SPI),
    .ss               (ss),
    .SPI_data         (SPI_data),
    .SPI_done         (SPI_done),
    .EEP_data         (EEP_data),
    .send_resp        (send_resp),
    .resp_data        (resp_data),
    .resp_sent        (resp_sent),
    .set_capture_done (set_capture_done),
    .trig_cfg         (trig_cfg),
    .trig_pos         (trig_pos),
    .decimator        (decimator),
    .dump             (dump),
    .dump_ch          (dump_ch),
    .afe_gain         (afe_gain)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state.
  logic [7:0]          gain_tbl [8] = '{8'h02, 8'h05, 8'h09, 8'h14, 8'h28, 8'h46, 8'h6B, 8'hDD};
  logic [2:0]          m_gain [NumCh];
  logic [7:0]          m_trig_cfg;
  logic [TrigPosW-1:0] m_trig_pos;
  logic [DecW-1:0]     m_dec;
  logic [1:0]          m_dump_ch;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3*NumCh-1:0] model_gain();
    logic [3*NumCh-1:0] v;
    for (int i = 0; i < NumCh; i++) v[3*i +: 3] = m_gain[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NumCh; i++) m_gain[i] = 3'd0;
    m_trig_cfg = 8'h00;
    m_trig_pos = '0;
    m_dec      = '0;
    m_dump_ch  = 2'd0;
  endtask

  task automatic check_cfg(input string tag);
    check_eq({tag, ".trig_cfg"}, trig_cfg, m_trig_cfg);
    check_eq({tag, ".trig_pos"}, trig_pos, m_trig_pos);
    check_eq({tag, ".decimator"}, decimator, m_dec);
    check_eq({tag, ".afe_gain"}, afe_gain, model_gain());
    check_eq({tag, ".dump_ch"}, dump_ch, m_dump_ch);
  endtask

  // kind: 0 dump, 1 SPI transaction, 2 immediate response.
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] b2, input logic [7:0] b3,
                         input logic [7:0] eep, input bit scd, input bit no_done);
    int          kind;
    int          cc;
    bit          cc_ok;
    int          e_ss;
    logic [15:0] e_data;
    logic [7:0]  e_resp;
    logic [15:0] pos_full;
    kind   = 2;
    e_resp = 8'hA5;
    e_ss   = 0;
    e_data = 16'h0;
    cc     = int'(b2[1:0]);
    cc_ok  = (cc < NumCh);
    case (op)
      8'h01: if (cc_ok) kind = 0; else e_resp = 8'hEE;
      8'h02: if (cc_ok) begin
               kind = 1; e_ss = cc + 1; e_data = {8'h13, gain_tbl[b3[4:2]]};
             end else e_resp = 8'hEE;
      8'h03: if (b3 >= 8'd46 && b3 <= 8'd201) begin
               kind = 1; e_ss = 0; e_data = {8'h13, b3};
             end else e_resp = 8'hEE;
      8'h04: begin pos_full = {b2, b3}; m_trig_pos = pos_full[TrigPosW-1:0]; end
      8'h05: m_dec = b3[DecW-1:0];
      8'h06: m_trig_cfg = b3 & 8'h3F;
      8'h07: e_resp = m_trig_cfg;
      8'h08: begin kind = 1; e_ss = NumCh + 1; e_data = {2'b01, b2[5:0], b3}; end
      8'h09: begin kind = 1; e_ss = NumCh + 1; e_data = {2'b00, b2[5:0], b3}; e_resp = eep; end
      8'h0A: e_resp = cc_ok ? {5'b0, m_gain[cc]} : 8'hEE;
      default: e_resp = 8'hEE;
    endcase

    @(negedge clk);
    cmd     = {op, b2, b3};
    cmd_rdy = 1'b1;
    @(negedge clk);
    set_capture_done = scd;
    @(negedge clk);
    set_capture_done = 1'b0;
    if (scd) m_trig_cfg = m_trig_cfg | 8'h20;
    check_eq("wrt_SPI", wrt_SPI, kind == 1);
    check_eq("send_resp", send_resp, kind == 2);
    check_eq("dump", dump, kind == 0);
    check_eq("clr_cmd_rdy", clr_cmd_rdy, kind != 1);

    if (kind == 0) begin
      cmd_rdy   = 1'b0;
      m_dump_ch = b2[1:0];
      check_eq("dump_ch", dump_ch, m_dump_ch);
      @(negedge clk);
      check_eq("dump_once", dump, 1'b0);
    end else begin
      if (kind == 1) begin
        check_eq("ss", ss, e_ss);
        check_eq("SPI_data", SPI_data, e_data);
        check_eq("gain_precommit", afe_gain, model_gain());
`ifdef CMD_TIMEOUT_EN
        if (no_done) begin
          int waited = 0;
          while (send_resp !== 1'b1 && waited < Tmo + 20) begin
            @(negedge clk);
            waited++;
          end
          check_eq("tmo_cycles", waited, Tmo);
          e_resp = 8'hEF;
        end else
`endif
        begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          check_eq("spi_wait_quiet", send_resp, 1'b0);
          SPI_done = 1'b1;
          EEP_data = eep;
          @(negedge clk);
          SPI_done = 1'b0;
          EEP_data = 8'($urandom);
          if (op == 8'h02) m_gain[cc] = b3[4:2];
        end
        check_eq("spi_send_resp", send_resp, 1'b1);
        check_eq("spi_clr", clr_cmd_rdy, 1'b1);
      end
      cmd_rdy = 1'b0;
      check_eq("resp_data", resp_data, e_resp);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check_eq("resp_once", send_resp, 1'b0);
      check_eq("resp_hold", resp_data, e_resp);
      resp_sent = 1'b1;
      @(negedge clk);
      resp_sent = 1'b0;
    end
    check_cfg("post");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_rdy = 1'b0; SPI_done = 1'b0; resp_sent = 1'b0; set_capture_done = 1'b0;
    cmd = 24'h0; EEP_data = 8'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] op, b2, b3;
    logic [7:0] lvl_edge [4];
    lvl_edge = '{8'd45, 8'd46, 8'd201, 8'd202};

    do_reset();
    check_eq("rst.wrt_SPI", wrt_SPI, 1'b0);
    check_eq("rst.send_resp", send_resp, 1'b0);
    check_eq("rst.clr", clr_cmd_rdy, 1'b0);
    check_eq("rst.dump", dump, 1'b0);
    check_eq("rst.SPI_data", SPI_data, 16'h0);
    check_eq("rst.resp_data", resp_data, 8'h0);
    check_eq("rst.ss", ss, 0);
    check_cfg("rst");

    run_cmd(8'h02, 8'h01, 8'h1C, 8'h00, 1'b0, 1'b0);
    check_eq("gain_ch2", afe_gain[5:3], 3'd7);
    run_cmd(8'h03, 8'h00, 8'h2D, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h03, 8'h00, 8'hC9, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h03, 8'h00, 8'h2E, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h03, 8'h00, 8'hCA, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h09, 8'h05, 8'h00, 8'h5A, 1'b0, 1'b0);
    run_cmd(8'h06, 8'h00, 8'h0F, 8'h00, 1'b1, 1'b0);
    run_cmd(8'h07, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h06, 8'h00, 8'h2F, 8'h00, 1'b1, 1'b0);
    run_cmd(8'h07, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h0A, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h0A, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h02, 8'h03, 8'h1C, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h01, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h01, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0);
    run_cmd(8'h0B, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef CMD_TIMEOUT_EN
    run_cmd(8'h08, 8'h01, 8'hAA, 8'h00, 1'b0, 1'b1);
    run_cmd(8'h02, 8'h00, 8'h14, 8'h00, 1'b0, 1'b1);
`endif

    // Reset while waiting on the SPI master: aborted silently, no late commit.
    @(negedge clk);
    cmd = 24'h02_00_14;
    cmd_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cmd_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    SPI_done = 1'b1;
    @(negedge clk);
    SPI_done = 1'b0;
    @(negedge clk);
    check_eq("midrst.send_resp", send_resp, 1'b0);
    check_eq("midrst.SPI_data", SPI_data, 16'h0);
    check_cfg("midrst");

    for (int n = 0; n < 200; n++) begin
      op = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) op = 8'hFF;
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      if (op == 8'h03 && $urandom_range(0, 1) == 1) b3 = lvl_edge[$urandom_range(0, 3)];
      run_cmd(op, b2, b3, 8'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        // Stray handshakes while idle must be ignored.
        SPI_done = 1'b1;
        resp_sent = 1'b1;
        set_capture_done = $urandom_range(0, 1) == 1;
        @(negedge clk);
        if (set_capture_done) m_trig_cfg = m_trig_cfg | 8'h20;
        SPI_done = 1'b0;
        resp_sent = 1'b0;
        set_capture_done = 1'b0;
        check_eq("idle.send_resp", send_resp, 1'b0);
        check_eq("idle.wrt_SPI", wrt_SPI, 1'b0);
        check_eq("idle.trig_cfg", trig_cfg, m_trig_cfg);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
